// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding memory access per request, with alignment,
// lane steering, load extension and a bounded wait for the memory response.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                cap_we;
    logic [1:0]          cap_size;
    logic                cap_unsigned;
    logic [1:0]          cap_lane;
    logic [CNT_W-1:0]    cnt;
    logic                misalign_c;
    logic [3:0]          be_c;
    logic [DATA_W-1:0]   wdata_c;
    logic [DATA_W-1:0]   shifted_c;
    logic [DATA_W-1:0]   load_c;
    logic                timeout_c;
    logic [DATA_W-1:0]   rsp_rdata_next;
    logic                rsp_err_next;

    // Request decode: alignment check and lane steering for the incoming request
    always_comb begin
        misalign_c = 1'b1;
        be_c       = 4'b0000;
        wdata_c    = req_wdata;
        case (req_size)
            2'b00: begin
                misalign_c = 1'b0;
                be_c       = 4'b0001 << req_addr[1:0];
                wdata_c    = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misalign_c = req_addr[0];
                be_c       = 4'b0011 << {req_addr[1], 1'b0};
                wdata_c    = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                misalign_c = (req_addr[1:0] != 2'b00);
                be_c       = 4'b1111;
                wdata_c    = req_wdata;
            end
            default: begin
                misalign_c = 1'b1;
                be_c       = 4'b0000;
                wdata_c    = req_wdata;
            end
        endcase
    end

    // Load data: shift the addressed lane down, then extend to 32 bits
    always_comb begin
        shifted_c = mem_rdata >> {cap_lane, 3'b000};
        load_c    = shifted_c;
        case (cap_size)
            2'b00:   load_c = cap_unsigned ? {24'd0, shifted_c[7:0]}
                                           : {{24{shifted_c[7]}}, shifted_c[7:0]};
            2'b01:   load_c = cap_unsigned ? {16'd0, shifted_c[15:0]}
                                           : {{16{shifted_c[15]}}, shifted_c[15:0]};
            default: load_c = shifted_c;
        endcase
    end

    assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the response that would be latched on RESP entry
    always_comb begin
        state_next     = state;
        rsp_rdata_next = '0;
        rsp_err_next   = 1'b1;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = misalign_c ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (timeout_c) begin
                    state_next = RESP;
                end else if (mem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_next     = RESP;
                    rsp_err_next   = 1'b0;
                    rsp_rdata_next = cap_we ? '0 : load_c;
                end else if (timeout_c) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
            end
            ISSUE: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = cap_we;
            end
            WAIT: begin
                stall = 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Request capture, timeout counter and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_we       <= 1'b0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_lane     <= 2'b00;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            cnt          <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                cap_we       <= req_we;
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
                cap_lane     <= req_addr[1:0];
                mem_addr     <= {req_addr[31:2], 2'b00};
                mem_be       <= be_c;
                mem_wdata    <= wdata_c;
                cnt          <= '0;
            end else if (state == ISSUE || state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state != RESP && state_next == RESP) begin
                rsp_rdata <= rsp_rdata_next;
                rsp_err   <= rsp_err_next;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected responses are queued when a
// request is driven and compared when rsp_valid pulses.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    rsp_t exp_rsp;
    int   total = 0;
    int   bad   = 0;

    load_store_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .stall        (stall),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset === 1'b1 && rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                exp_rsp = sb.pop_front();
                check("rsp_rdata", rsp_rdata, exp_rsp.rd);
                check("rsp_err", 32'(rsp_err), 32'(exp_rsp.err));
            end
        end
    end

    // mode: 0 normal, 1 rejected before memory, 2 no grant ever, 3 grant but no rvalid
    task automatic txn(input int mode, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int n;
        rsp_t e;
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        e.rd  = exp_rd;
        e.err = exp_err;
        sb.push_back(e);
        #1;
        check("stall_accept", 32'(stall), 32'd1);
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = ~uns;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        if (mode == 1) begin
            check("no_mem_req", 32'(mem_req), 32'd0);
            check("rsp_next_cycle", 32'(rsp_valid), 32'd1);
        end else begin
            check("mem_req_issue", 32'(mem_req), 32'd1);
            check("mem_we", 32'(mem_we), 32'(we));
            check("mem_addr", mem_addr, {addr[31:2], 2'b00});
            check("mem_be", 32'(mem_be), 32'(exp_be));
            check("mem_wdata", mem_wdata, exp_wd);
            if (mode == 2) begin
                n = 0;
                while (mem_req === 1'b1 && n < 50) begin
                    n++;
                    @(posedge clk); #1;
                end
                check("timeout_issue_cycles", 32'(n), 32'(TO));
            end else begin
                repeat (gnt_wait) begin
                    @(posedge clk); #1;
                    check("mem_req_held", 32'(mem_req), 32'd1);
                    check("mem_addr_held", mem_addr, {addr[31:2], 2'b00});
                end
                mem_gnt = 1'b1;
                @(posedge clk); #1;
                mem_gnt = 1'b0;
                check("mem_req_wait", 32'(mem_req), 32'd0);
                check("stall_wait", 32'(stall), 32'd1);
                if (mode == 3) begin
                    n = 0;
                    while (rsp_valid !== 1'b1 && n < 50) begin
                        n++;
                        @(posedge clk); #1;
                    end
                    check("timeout_wait_cycles", 32'(n), 32'(TO - 1 - gnt_wait));
                end else begin
                    repeat (rv_wait) begin
                        @(posedge clk); #1;
                    end
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata;
                    @(posedge clk); #1;
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom;
                end
            end
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("stall_resp", 32'(stall), 32'd0);
        check("ready_resp", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check("rsp_rdata_held", rsp_rdata, exp_rd);
    endtask

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        txn(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h12345678, 32'hDEADBEEF, 0, 0,
            32'hDEADBEEF, 1'b0, 4'b1111, 32'h12345678);
        txn(0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h000000A5, 32'h80112233, 0, 0,
            32'hFFFFFF80, 1'b0, 4'b1000, 32'hA5A5A5A5);
        txn(0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h000000A5, 32'h80112233, 1, 0,
            32'h00000080, 1'b0, 4'b1000, 32'hA5A5A5A5);
        txn(0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'hFFFFFFFF, 0, 1,
            32'h0, 1'b0, 4'b1100, 32'hABCDABCD);
        txn(0, 1'b0, 2'b01, 1'b0, 32'h002, 32'h0, 32'h80017FFF, 1, 1,
            32'hFFFF8001, 1'b0, 4'b1100, 32'h0);
        txn(0, 1'b0, 2'b01, 1'b1, 32'h000, 32'h0, 32'h1234F00D, 0, 0,
            32'h0000F00D, 1'b0, 4'b0011, 32'h0);
        txn(0, 1'b1, 2'b00, 1'b0, 32'h301, 32'h1234565A, 32'h0, 0, 0,
            32'h0, 1'b0, 4'b0010, 32'h5A5A5A5A);
        // rvalid on the very cycle the timeout would fire: completion wins
        txn(0, 1'b0, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 32'h600DF00D, 0, 2,
            32'h600DF00D, 1'b0, 4'b1111, 32'hCAFEF00D);
        txn(1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1, 4'b0, 32'h0);
        txn(1, 1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1, 4'b0, 32'h0);
        txn(1, 1'b1, 2'b11, 1'b0, 32'h000, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1, 4'b0, 32'h0);
        txn(2, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1, 4'b1111, 32'h0);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h504, 32'h0, 32'h01020304, 0, 0,
            32'h01020304, 1'b0, 4'b1111, 32'h0);
        txn(3, 1'b1, 2'b10, 1'b0, 32'h600, 32'h77, 32'h0, 0, 0, 32'h0, 1'b1, 4'b1111, 32'h77);

        // Reset in the middle of a transaction: abandoned with no response
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h700;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("pre_reset_stall", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBADBAD00;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check("late_rvalid_ignored", 32'(rsp_valid), 32'd0);
        check("late_rvalid_ready", 32'(req_ready), 32'd1);

        txn(0, 1'b0, 2'b00, 1'b0, 32'h802, 32'h0, 32'h00C30000, 0, 0,
            32'hFFFFFFC3, 1'b0, 4'b0100, 32'h0);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
